// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control unit: Moore sequencer, ALU decoder and PC-enable logic.
// Optional macro MC_BNE_EN adds bne (op 000101) support through the BRANCH state.
module mips_mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       iord,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  state_t     state_p0;
  state_t     state_nxt;
  logic [1:0] aluop;
  logic       pcwrite;
  logic       branch;
  logic       memwrite_raw;
  logic       irwrite_raw;
  logic       regwrite_raw;
  logic       unused_st;
  logic       br_taken;
  logic [2:0] alu_dec;

  // ---- state register (the only storage) ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_p0 <= FETCH;
    else        state_p0 <= state_nxt;
  end

  // ---- next state and Moore outputs ----
  always_comb begin
    state_nxt    = FETCH;
    aluop        = 2'b00;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    memwrite_raw = 1'b0;
    irwrite_raw  = 1'b0;
    regwrite_raw = 1'b0;
    unused_st    = 1'b0;
    iord         = 1'b0;
    memtoreg     = 1'b0;
    regdst       = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    pcsrc        = 2'b00;
    case (state_p0)
      FETCH: begin
        alusrcb     = 2'b01;
        irwrite_raw = 1'b1;
        pcwrite     = 1'b1;
        state_nxt   = DECODE;
      end
      DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_nxt = MEMADR;
          OP_RTYPE:     state_nxt = EXECUTE;
          OP_BEQ:       state_nxt = BRANCH;
`ifdef MC_BNE_EN
          OP_BNE:       state_nxt = BRANCH;
`endif
          OP_ADDI:      state_nxt = ADDIEXEC;
          OP_J:         state_nxt = JUMP;
          default:      state_nxt = FETCH;
        endcase
      end
      MEMADR: begin
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        state_nxt = (op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        iord      = 1'b1;
        state_nxt = MEMWB;
      end
      MEMWB: begin
        memtoreg     = 1'b1;
        regwrite_raw = 1'b1;
      end
      MEMWR: begin
        iord         = 1'b1;
        memwrite_raw = 1'b1;
      end
      EXECUTE: begin
        alusrca   = 1'b1;
        aluop     = 2'b10;
        state_nxt = ALUWB;
      end
      ALUWB: begin
        regdst       = 1'b1;
        regwrite_raw = 1'b1;
      end
      BRANCH: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      ADDIEXEC: begin
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        state_nxt = ADDIWB;
      end
      ADDIWB: regwrite_raw = 1'b1;
      JUMP: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: unused_st = 1'b1;
    endcase
  end

  // ---- ALU decoder ----
  always_comb begin
    alu_dec = 3'b010;
    case (aluop)
      2'b01: alu_dec = 3'b110;
      2'b10: begin
        case (funct)
          6'b100010: alu_dec = 3'b110;
          6'b100100: alu_dec = 3'b000;
          6'b100101: alu_dec = 3'b001;
          6'b101010: alu_dec = 3'b111;
          default:   alu_dec = 3'b010;
        endcase
      end
      default: alu_dec = 3'b010;
    endcase
  end

  // Unreachable encodings drive every output to zero, ALU control included.
  assign alucontrol = unused_st ? 3'b000 : alu_dec;

`ifdef MC_BNE_EN
  assign br_taken = branch & ((op == OP_BNE) ? ~zero : zero);
`else
  assign br_taken = branch & zero;
`endif

  // Write enables are blocked while reset is held so no write fires mid-abort.
  assign pcen     = reset & (pcwrite | br_taken);
  assign memwrite = reset & memwrite_raw;
  assign irwrite  = reset & irwrite_raw;
  assign regwrite = reset & regwrite_raw;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Self-checking bench for mips_mc_controller: per-cycle vector table plus reset corner cases.
module tb_mips_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;

  mips_mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .iord(iord), .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol)
  );

  always #10 clk = ~clk;

  // Packed order: pcen,memwrite,irwrite,regwrite,iord,memtoreg,regdst,alusrca,alusrcb,pcsrc,alucontrol
  function automatic logic [14:0] pk(input logic pe, mw, ir, rw, io, m2r, rd, asa,
                                     input logic [1:0] asb, pcs, input logic [2:0] alu);
    return {pe, mw, ir, rw, io, m2r, rd, asa, asb, pcs, alu};
  endfunction

  logic [14:0] act;
  assign act = {pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst, alusrca,
                alusrcb, pcsrc, alucontrol};

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic [14:0] exp;
    string       name;
  } vec_t;

  typedef struct {
    logic [14:0] exp;
    string       name;
  } sb_t;

  vec_t vecs[$];
  sb_t  sbq[$];
  int   n_run  = 0;
  int   n_fail = 0;

  logic [14:0] E_FETCH, E_RST, E_DECODE, E_MEMADR, E_MEMRD, E_MEMWB, E_MEMWR;
  logic [14:0] E_ALUWB, E_ADDIEXEC, E_ADDIWB, E_JUMP;

  function automatic logic [14:0] e_exec(input logic [2:0] alu);
    return pk(0,0,0,0,0,0,0,1, 2'b00, 2'b00, alu);
  endfunction

  function automatic logic [14:0] e_branch(input logic taken);
    return pk(taken,0,0,0,0,0,0,1, 2'b00, 2'b01, 3'b110);
  endfunction

  task automatic add(input logic [5:0] o, input logic [5:0] f, input logic z,
                     input logic [14:0] e, input string n);
    vec_t v;
    v.op = o; v.funct = f; v.zero = z; v.exp = e; v.name = n;
    vecs.push_back(v);
  endtask

  task automatic push(input logic [14:0] e, input string n);
    sb_t s;
    s.exp = e; s.name = n;
    sbq.push_back(s);
  endtask

  task automatic check_now();
    sb_t s;
    n_run++;
    if (sbq.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty got %b", act);
    end else begin
      s = sbq.pop_front();
      if (act !== s.exp) begin
        n_fail++;
        $display("FAIL %s got %b expected %b", s.name, act, s.exp);
      end
    end
  endtask

  // One cycle: drive inputs just after posedge, check at negedge, advance to next posedge.
  task automatic step(input logic [5:0] o, input logic [5:0] f, input logic z,
                      input logic [14:0] e, input string n);
    op = o; funct = f; zero = z;
    push(e, n);
    @(negedge clk);
    check_now();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    E_FETCH    = pk(1,0,1,0,0,0,0,0, 2'b01, 2'b00, 3'b010);
    E_RST      = pk(0,0,0,0,0,0,0,0, 2'b01, 2'b00, 3'b010);
    E_DECODE   = pk(0,0,0,0,0,0,0,0, 2'b11, 2'b00, 3'b010);
    E_MEMADR   = pk(0,0,0,0,0,0,0,1, 2'b10, 2'b00, 3'b010);
    E_MEMRD    = pk(0,0,0,0,1,0,0,0, 2'b00, 2'b00, 3'b010);
    E_MEMWB    = pk(0,0,0,1,0,1,0,0, 2'b00, 2'b00, 3'b010);
    E_MEMWR    = pk(0,1,0,0,1,0,0,0, 2'b00, 2'b00, 3'b010);
    E_ALUWB    = pk(0,0,0,1,0,0,1,0, 2'b00, 2'b00, 3'b010);
    E_ADDIEXEC = pk(0,0,0,0,0,0,0,1, 2'b10, 2'b00, 3'b010);
    E_ADDIWB   = pk(0,0,0,1,0,0,0,0, 2'b00, 2'b00, 3'b010);
    E_JUMP     = pk(1,0,0,0,0,0,0,0, 2'b00, 2'b10, 3'b010);

    // lw: 5 cycles
    add(6'b100011, 6'h00, 0, E_FETCH,  "lw_fetch");
    add(6'b100011, 6'h00, 0, E_DECODE, "lw_decode");
    add(6'b100011, 6'h00, 0, E_MEMADR, "lw_memadr");
    add(6'b100011, 6'h00, 0, E_MEMRD,  "lw_memrd");
    add(6'b100011, 6'h00, 0, E_MEMWB,  "lw_memwb");
    // R-type sub, slt, unknown funct
    add(6'b000000, 6'b100010, 0, E_FETCH,         "sub_fetch");
    add(6'b000000, 6'b100010, 0, E_DECODE,        "sub_decode");
    add(6'b000000, 6'b100010, 0, e_exec(3'b110),  "sub_execute");
    add(6'b000000, 6'b100010, 0, E_ALUWB,         "sub_aluwb");
    add(6'b000000, 6'b101010, 0, E_FETCH,         "slt_fetch");
    add(6'b000000, 6'b101010, 0, E_DECODE,        "slt_decode");
    add(6'b000000, 6'b101010, 0, e_exec(3'b111),  "slt_execute");
    add(6'b000000, 6'b101010, 0, E_ALUWB,         "slt_aluwb");
    add(6'b000000, 6'b111111, 0, E_FETCH,         "rbad_fetch");
    add(6'b000000, 6'b111111, 0, E_DECODE,        "rbad_decode");
    add(6'b000000, 6'b111111, 0, e_exec(3'b010),  "rbad_execute");
    add(6'b000000, 6'b111111, 0, E_ALUWB,         "rbad_aluwb");
    add(6'b000000, 6'b100101, 0, E_FETCH,         "or_fetch");
    add(6'b000000, 6'b100101, 0, E_DECODE,        "or_decode");
    add(6'b000000, 6'b100101, 0, e_exec(3'b001),  "or_execute");
    add(6'b000000, 6'b100101, 0, E_ALUWB,         "or_aluwb");
    // beq taken and not taken: 3 cycles each
    add(6'b000100, 6'h00, 1, E_FETCH,        "beq1_fetch");
    add(6'b000100, 6'h00, 1, E_DECODE,       "beq1_decode");
    add(6'b000100, 6'h00, 1, e_branch(1'b1), "beq1_branch");
    add(6'b000100, 6'h00, 0, E_FETCH,        "beq0_fetch");
    add(6'b000100, 6'h00, 0, E_DECODE,       "beq0_decode");
    add(6'b000100, 6'h00, 0, e_branch(1'b0), "beq0_branch");
    // j
    add(6'b000010, 6'h00, 0, E_FETCH,  "j_fetch");
    add(6'b000010, 6'h00, 0, E_DECODE, "j_decode");
    add(6'b000010, 6'h00, 0, E_JUMP,   "j_jump");
    // illegal op: 2 cycles
    add(6'b111111, 6'h00, 0, E_FETCH,  "ill_fetch");
    add(6'b111111, 6'h00, 0, E_DECODE, "ill_decode");
    // addi
    add(6'b001000, 6'h00, 0, E_FETCH,    "addi_fetch");
    add(6'b001000, 6'h00, 0, E_DECODE,   "addi_decode");
    add(6'b001000, 6'h00, 0, E_ADDIEXEC, "addi_exec");
    add(6'b001000, 6'h00, 0, E_ADDIWB,   "addi_wb");
    // bne
    add(6'b000101, 6'h00, 0, E_FETCH,  "bne_fetch");
    add(6'b000101, 6'h00, 0, E_DECODE, "bne_decode");
`ifdef MC_BNE_EN
    add(6'b000101, 6'h00, 0, e_branch(1'b1), "bne0_branch");
    add(6'b000101, 6'h00, 1, E_FETCH,        "bne1_fetch");
    add(6'b000101, 6'h00, 1, E_DECODE,       "bne1_decode");
    add(6'b000101, 6'h00, 1, e_branch(1'b0), "bne1_branch");
`endif
    // sw ending in a clean fetch
    add(6'b101011, 6'h00, 0, E_FETCH,  "sw_fetch");
    add(6'b101011, 6'h00, 0, E_DECODE, "sw_decode");
    add(6'b101011, 6'h00, 0, E_MEMADR, "sw_memadr");
    add(6'b101011, 6'h00, 0, E_MEMWR,  "sw_memwr");
    add(6'b000000, 6'h00, 0, E_FETCH,  "after_sw_fetch");

    // Reset held for two clocks with lw on the op bus
    reset = 1'b0; op = 6'b100011; funct = 6'h00; zero = 1'b0;
    repeat (2) @(posedge clk);
    push(E_RST, "reset_hold");
    @(negedge clk);
    check_now();
    @(posedge clk);
    #1;
    reset = 1'b1;

    foreach (vecs[i]) step(vecs[i].op, vecs[i].funct, vecs[i].zero, vecs[i].exp, vecs[i].name);

    // sw interrupted by reset in MEMWR
    step(6'b101011, 6'h00, 0, E_DECODE, "swr_decode");
    step(6'b101011, 6'h00, 0, E_MEMADR, "swr_memadr");
    op = 6'b101011;
    push(E_MEMWR, "swr_memwr");
    @(negedge clk);
    check_now();
    #3 reset = 1'b0;
    #1 push(E_RST, "swr_reset_async");
    check_now();
    #2 reset = 1'b1;
    #1 push(E_FETCH, "swr_refetch");
    check_now();
    @(posedge clk);
    #1;
    step(6'b101011, 6'h00, 0, E_DECODE, "swr_redecode");

    if (sbq.size() != 0) begin
      n_run++;
      n_fail++;
      $display("FAIL scoreboard_leftover got %0d entries expected 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
